// File: rtl/hilo_acc_bank_pkg.sv
// hilo_acc_bank_pkg
//   Shared types for the HI/LO accumulator bank: command encoding and a
//   decoder that folds undefined command codes onto HiloNop.
package hilo_acc_bank_pkg;

    localparam int unsigned HiloCmdW = 3;

    typedef enum logic [HiloCmdW-1:0] {
        HiloNop  = 3'd0,
        HiloWr   = 3'd1,
        HiloMadd = 3'd2,
        HiloMsub = 3'd3,
        HiloClr  = 3'd4
    } hilo_cmd_e;

    // Undefined encodings behave exactly like HiloNop.
    function automatic hilo_cmd_e decode_cmd(input logic [HiloCmdW-1:0] raw);
        case (raw)
            3'd1:    return HiloWr;
            3'd2:    return HiloMadd;
            3'd3:    return HiloMsub;
            3'd4:    return HiloClr;
            default: return HiloNop;
        endcase
    endfunction

endpackage

// File: rtl/hilo_acc_bank_if.sv
// hilo_acc_bank_if
//   Command, read-port and architectural-output bundle of hilo_acc_bank.
//   slave  : the accumulator bank (consumes commands, drives read data/status)
//   master : the pipeline side (issues commands, selects and reads accumulators)
//   Signals: cmd_i/ac_i/we_hi_i/we_lo_i/hi_i/lo_i/prod_i  command to the bank
//            rac_i                                         read-port select
//            rd_hi_o/rd_lo_o/rd_pend_o                     read data and hazard flag
//            hi_o/lo_o/ovf_o                               registered ac0 and overflow flags
interface hilo_acc_bank_if
    import hilo_acc_bank_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_AC   = 4,
    parameter int unsigned AC_SEL_W = 2
) ();

    logic [HiloCmdW-1:0] cmd_i;
    logic [AC_SEL_W-1:0] ac_i;
    logic                we_hi_i;
    logic                we_lo_i;
    logic [DATA_W-1:0]   hi_i;
    logic [DATA_W-1:0]   lo_i;
    logic [2*DATA_W-1:0] prod_i;
    logic [AC_SEL_W-1:0] rac_i;
    logic [DATA_W-1:0]   rd_hi_o;
    logic [DATA_W-1:0]   rd_lo_o;
    logic                rd_pend_o;
    logic [DATA_W-1:0]   hi_o;
    logic [DATA_W-1:0]   lo_o;
    logic [NUM_AC-1:0]   ovf_o;

    modport slave (
        input  cmd_i, ac_i, we_hi_i, we_lo_i, hi_i, lo_i, prod_i, rac_i,
        output rd_hi_o, rd_lo_o, rd_pend_o, hi_o, lo_o, ovf_o
    );

    modport master (
        output cmd_i, ac_i, we_hi_i, we_lo_i, hi_i, lo_i, prod_i, rac_i,
        input  rd_hi_o, rd_lo_o, rd_pend_o, hi_o, lo_o, ovf_o
    );

endinterface

// File: rtl/hilo_acc_alu.sv
// hilo_acc_alu
//   Combinational accumulate datapath: sum_o = acc_i +/- prod_i, modulo
//   2^(2*DATA_W), with two's-complement signed-overflow detection.
//   acc_i  : current accumulator value {hi, lo}
//   prod_i : signed product operand
//   sub_i  : 1 = subtract (MSUB), 0 = add (MADD)
//   sum_o  : wrapped result
//   ovf_o  : signed overflow of this operation
module hilo_acc_alu #(
    parameter int unsigned DATA_W = 32
) (
    input  logic [2*DATA_W-1:0] acc_i,
    input  logic [2*DATA_W-1:0] prod_i,
    input  logic                sub_i,
    output logic [2*DATA_W-1:0] sum_o,
    output logic                ovf_o
);

    localparam int unsigned AccW = 2 * DATA_W;

    logic acc_s;
    logic prod_s;
    logic sum_s;

    assign sum_o  = sub_i ? (acc_i - prod_i) : (acc_i + prod_i);
    assign acc_s  = acc_i[AccW-1];
    assign prod_s = prod_i[AccW-1];
    assign sum_s  = sum_o[AccW-1];

    // Add overflows when operand signs agree; subtract when they differ.
    // In both cases the result sign then flips away from the accumulator sign.
    assign ovf_o = ((sub_i ? (acc_s != prod_s) : (acc_s == prod_s))) && (sum_s != acc_s);

endmodule

// File: rtl/hilo_acc_bank.sv
// hilo_acc_bank
//   Bank of NUM_AC accumulators of 2*DATA_W bits; ac0 is the architectural
//   HI/LO pair. Commands are captured into E1 on one edge and executed
//   (array written) on the next; the execute stage reads the live array, so
//   back-to-back commands to one accumulator chain without forwarding.
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-low reset
//   bus  : command input, read port (E2-bypassed), hazard flag,
//          registered ac0 HI/LO and sticky per-accumulator overflow flags
module hilo_acc_bank
    import hilo_acc_bank_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_AC   = 4,
    parameter int unsigned AC_SEL_W = 2
) (
    input logic            clk,
    input logic            rst,
    hilo_acc_bank_if.slave bus
);

    localparam int unsigned AccW = 2 * DATA_W;

    // Architectural state
    logic [AccW-1:0]   acc_q [NUM_AC];
    logic [NUM_AC-1:0] ovf_q;
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;

    // E1 stage
    logic                e1_valid_q;
    hilo_cmd_e           e1_cmd_q;
    logic [AC_SEL_W-1:0] e1_ac_q;
    logic                e1_we_hi_q;
    logic                e1_we_lo_q;
    logic [DATA_W-1:0]   e1_hi_q;
    logic [DATA_W-1:0]   e1_lo_q;
    logic [AccW-1:0]     e1_prod_q;

    // Capture decode
    hilo_cmd_e cap_cmd;
    logic      cap_ac_ok;
    logic      cap_valid;

    assign cap_cmd   = decode_cmd(bus.cmd_i);
    assign cap_ac_ok = 32'(bus.ac_i) < NUM_AC;
    assign cap_valid = (cap_cmd != HiloNop) && cap_ac_ok;

    // E2 execute
    logic [AccW-1:0] ex_cur;
    logic [AccW-1:0] ex_val;
    logic            ex_we;
    logic            ex_ovf_set;
    logic            ex_ovf_clr;
    logic [AccW-1:0] alu_sum;
    logic            alu_ovf;

    assign ex_cur = acc_q[e1_ac_q];

    hilo_acc_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .acc_i  (ex_cur),
        .prod_i (e1_prod_q),
        .sub_i  (e1_cmd_q == HiloMsub),
        .sum_o  (alu_sum),
        .ovf_o  (alu_ovf)
    );

    always_comb begin
        ex_we      = 1'b0;
        ex_val     = ex_cur;
        ex_ovf_set = 1'b0;
        ex_ovf_clr = 1'b0;
        if (e1_valid_q) begin
            case (e1_cmd_q)
                HiloWr: begin
                    ex_we  = e1_we_hi_q | e1_we_lo_q;
                    ex_val = {e1_we_hi_q ? e1_hi_q : ex_cur[AccW-1:DATA_W],
                              e1_we_lo_q ? e1_lo_q : ex_cur[DATA_W-1:0]};
                end
                HiloMadd, HiloMsub: begin
                    ex_we      = 1'b1;
                    ex_val     = alu_sum;
                    ex_ovf_set = alu_ovf;
                end
                HiloClr: begin
                    ex_we      = 1'b1;
                    ex_val     = '0;
                    ex_ovf_clr = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            e1_valid_q <= 1'b0;
            e1_cmd_q   <= HiloNop;
            e1_ac_q    <= '0;
            e1_we_hi_q <= 1'b0;
            e1_we_lo_q <= 1'b0;
            e1_hi_q    <= '0;
            e1_lo_q    <= '0;
            e1_prod_q  <= '0;
            for (int i = 0; i < NUM_AC; i++) begin
                acc_q[i] <= '0;
            end
            ovf_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            e1_valid_q <= cap_valid;
            e1_cmd_q   <= cap_valid ? cap_cmd : HiloNop;
            e1_ac_q    <= bus.ac_i;
            e1_we_hi_q <= bus.we_hi_i;
            e1_we_lo_q <= bus.we_lo_i;
            e1_hi_q    <= bus.hi_i;
            e1_lo_q    <= bus.lo_i;
            e1_prod_q  <= bus.prod_i;

            if (ex_we) begin
                acc_q[e1_ac_q] <= ex_val;
                // hi_o/lo_o mirror ac0 on the same edge as the array write
                if (e1_ac_q == '0) begin
                    hi_q <= ex_val[AccW-1:DATA_W];
                    lo_q <= ex_val[DATA_W-1:0];
                end
            end
            if (ex_ovf_set) begin
                ovf_q[e1_ac_q] <= 1'b1;
            end
            if (ex_ovf_clr) begin
                ovf_q[e1_ac_q] <= 1'b0;
            end
        end
    end

    // Read port: forward the value E2 is about to write, else the array.
    logic            rd_hit;
    logic            rd_ok;
    logic [AccW-1:0] rd_val;

    assign rd_hit = ex_we && (e1_ac_q == bus.rac_i);
    assign rd_ok  = 32'(bus.rac_i) < NUM_AC;
    assign rd_val = rd_hit ? ex_val : (rd_ok ? acc_q[bus.rac_i] : '0);

    assign bus.rd_hi_o   = rd_val[AccW-1:DATA_W];
    assign bus.rd_lo_o   = rd_val[DATA_W-1:0];
    assign bus.rd_pend_o = e1_valid_q && (e1_cmd_q != HiloNop) && (e1_ac_q == bus.rac_i);
    assign bus.hi_o      = hi_q;
    assign bus.lo_o      = lo_q;
    assign bus.ovf_o     = ovf_q;

endmodule

// File: tb/tb_hilo_acc_bank.sv
module tb_hilo_acc_bank;
    import hilo_acc_bank_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    hilo_acc_bank_if #(.DATA_W(32), .NUM_AC(4), .AC_SEL_W(2)) bus ();

    hilo_acc_bank #(
        .DATA_W   (32),
        .NUM_AC   (4),
        .AC_SEL_W (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one command for exactly one edge, then return to NOP.
    task automatic issue(input logic [2:0] c, input logic [1:0] a, input logic wh,
                         input logic wl, input logic [31:0] h, input logic [31:0] l,
                         input logic [63:0] p);
        bus.cmd_i   = c;
        bus.ac_i    = a;
        bus.we_hi_i = wh;
        bus.we_lo_i = wl;
        bus.hi_i    = h;
        bus.lo_i    = l;
        bus.prod_i  = p;
        step();
        bus.cmd_i   = 3'd0;
        bus.we_hi_i = 1'b0;
        bus.we_lo_i = 1'b0;
    endtask

    task automatic read_ac(input logic [1:0] r, output logic [63:0] v);
        bus.rac_i = r;
        #1;
        v = {bus.rd_hi_o, bus.rd_lo_o};
    endtask

    logic [63:0] v;

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b0;
        bus.cmd_i   = 3'd0;
        bus.ac_i    = '0;
        bus.we_hi_i = 1'b0;
        bus.we_lo_i = 1'b0;
        bus.hi_i    = '0;
        bus.lo_i    = '0;
        bus.prod_i  = '0;
        bus.rac_i   = '0;
        idle(2);
        rst = 1'b1;

        // 1. Random ops, then reset with a command presented during reset
        issue(HiloWr, 2'd0, 1'b1, 1'b1, $urandom, $urandom, 64'd0);
        issue(HiloMadd, 2'd2, 1'b0, 1'b0, 32'd0, 32'd0, {$urandom, $urandom});
        issue(HiloWr, 2'd3, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0);
        rst         = 1'b0;
        bus.cmd_i   = HiloWr;
        bus.ac_i    = 2'd1;
        bus.we_hi_i = 1'b1;
        bus.we_lo_i = 1'b1;
        bus.hi_i    = 32'hFFFF_0001;
        bus.lo_i    = 32'hFFFF_0002;
        idle(2);
        rst         = 1'b1;
        bus.cmd_i   = 3'd0;
        bus.we_hi_i = 1'b0;
        bus.we_lo_i = 1'b0;
        idle(2);
        for (int r = 0; r < 4; r++) begin
            read_ac(r[1:0], v);
            chk($sformatf("reset_ac%0d", r), v, 64'd0);
        end
        chk("reset_hi_o", 64'(bus.hi_o), 64'd0);
        chk("reset_lo_o", 64'(bus.lo_o), 64'd0);
        chk("reset_ovf", 64'(bus.ovf_o), 64'd0);

        // 2. Full write to ac0, then LO-only write
        issue(HiloWr, 2'd0, 1'b1, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 64'd0);
        chk("wr_hi_o_one_edge", 64'(bus.hi_o), 64'd0);
        step();
        chk("wr_hi_o", 64'(bus.hi_o), 64'h1234_5678);
        chk("wr_lo_o", 64'(bus.lo_o), 64'h9ABC_DEF0);
        issue(HiloWr, 2'd0, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'd0, 64'd0);
        step();
        chk("wrlo_hi_kept", 64'(bus.hi_o), 64'h1234_5678);
        chk("wrlo_lo_zero", 64'(bus.lo_o), 64'd0);
        // Undefined code behaves as NOP
        issue(3'd7, 2'd0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd5);
        read_ac(2'd0, v);
        chk("undef_no_pend", 64'(bus.rd_pend_o), 64'd0);
        step();
        chk("undef_hi_kept", 64'(bus.hi_o), 64'h1234_5678);

        // 3. Back-to-back MADD chain on ac1, then MSUB below zero
        bus.rac_i = 2'd1;
        issue(HiloMadd, 2'd1, 1'b0, 1'b0, 32'd0, 32'd0, 64'd1);
        issue(HiloMadd, 2'd1, 1'b0, 1'b0, 32'd0, 32'd0, 64'd1);
        issue(HiloMadd, 2'd1, 1'b0, 1'b0, 32'd0, 32'd0, 64'd1);
        step();
        read_ac(2'd1, v);
        chk("madd_chain", v, 64'd3);
        issue(HiloMsub, 2'd1, 1'b0, 1'b0, 32'd0, 32'd0, 64'd5);
        step();
        read_ac(2'd1, v);
        chk("msub_neg", v, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("msub_no_ovf", 64'(bus.ovf_o), 64'd0);
        chk("ac0_untouched", 64'(bus.hi_o), 64'h1234_5678);

        // 4. Signed overflow on ac2, sticky, cleared by Clr
        issue(HiloWr, 2'd2, 1'b1, 1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 64'd0);
        issue(HiloMadd, 2'd2, 1'b0, 1'b0, 32'd0, 32'd0, 64'd1);
        step();
        read_ac(2'd2, v);
        chk("ovf_wrap", v, 64'h8000_0000_0000_0000);
        chk("ovf_set", 64'(bus.ovf_o), 64'h4);
        issue(HiloMadd, 2'd2, 1'b0, 1'b0, 32'd0, 32'd0, 64'd0);
        step();
        chk("ovf_sticky", 64'(bus.ovf_o), 64'h4);
        issue(HiloClr, 2'd2, 1'b0, 1'b0, 32'd0, 32'd0, 64'd0);
        step();
        read_ac(2'd2, v);
        chk("clr_val", v, 64'd0);
        chk("clr_ovf", 64'(bus.ovf_o), 64'd0);

        // 5. Hazard flag and E2 bypass on ac3
        bus.rac_i = 2'd3;
        issue(HiloWr, 2'd3, 1'b1, 1'b1, 32'hCAFE_F00D, 32'h0BAD_BEEF, 64'd0);
        chk("pend_hit", 64'(bus.rd_pend_o), 64'd1);
        read_ac(2'd3, v);
        chk("bypass_val", v, 64'hCAFE_F00D_0BAD_BEEF);
        read_ac(2'd2, v);
        chk("pend_other2", 64'(bus.rd_pend_o), 64'd0);
        read_ac(2'd0, v);
        chk("pend_other0", 64'(bus.rd_pend_o), 64'd0);
        bus.rac_i = 2'd3;
        step();
        chk("pend_drop", 64'(bus.rd_pend_o), 64'd0);
        read_ac(2'd3, v);
        chk("array_val", v, 64'hCAFE_F00D_0BAD_BEEF);

        // 6. Reset while a MADD executes: nothing lands
        bus.rac_i = 2'd1;
        issue(HiloMadd, 2'd1, 1'b0, 1'b0, 32'd0, 32'd0, 64'd5);
        rst = 1'b0;
        step();
        rst = 1'b1;
        read_ac(2'd1, v);
        chk("rst_e2_ac1", v, 64'd0);
        chk("rst_e2_hi_o", 64'(bus.hi_o), 64'd0);
        idle(2);
        read_ac(2'd1, v);
        chk("rst_e2_late", v, 64'd0);
        read_ac(2'd3, v);
        chk("rst_e2_ac3", v, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
